multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Registered control FSM for the multi-cycle RV32I core; the sequential successor to the single-cycle main/ALU decoder pair. Decodes `Op`/`funct3`/`funct7` once per instruction and sequences datapath enables over 3–5 cycles. Stalls on a memory ready handshake, with an optional stall timeout. Adds `bne` and optional `jal` support.

## Interface
- `EN_BNE`, default 1: 1 = `funct3=001` branches on `~Zero`; 0 = treated as illegal.
- `EN_JAL`, default 1: 1 = opcode `1101111` supported; 0 = treated as illegal.
- `TIMEOUT_CYCLES`, default 0: maximum consecutive memory-stall cycles; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `Op` in 7: opcode from the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7` in 7: instruction bits [31:25].
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction register and OldPC enable.
- `MemWrite` out 1: data memory write strobe.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: ALU B select; 00 = rs2, 01 = Imm, 10 = constant 4.
- `ImmSrc` out 2: immediate format.
- `ALUControl` out 3: ALU operation.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal_instr` out 1: one-cycle pulse on an unsupported opcode or branch `funct3`.
- `mem_timeout` out 1: one-cycle pulse when a memory stall is aborted.
- `state_o` out 4: current state code, for debug.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10. Codes 11–15 are unreachable and return to FETCH.
- Outputs are a combinational decode of the state, `Op`, `funct3`, `funct7`, `Zero` and `mem_ready`. Any signal not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by opcode:
  - `0000011` or `0100011` → MEMADR.
  - `0110011` → EXECUTER.
  - `0010011` → EXECUTEI.
  - `1100011` → BRANCH.
  - `1101111` → JAL when EN_JAL=1.
  - Any other opcode → FETCH, with an `illegal_instr` pulse.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Loads go to MEMREAD, stores go to MEMWRITE.
- MEMREAD: AdrSrc=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, `instr_done`=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held for the whole state. On `mem_ready`, pulse `instr_done` and go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, `instr_done`=1. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - `funct3=000`: PCWrite = `Zero`.
  - `funct3=001` with EN_BNE=1: PCWrite = `~Zero`.
  - Any other `funct3`: PCWrite=0, `illegal_instr` pulses.
  - `instr_done`=1 in every case. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB.
- ImmSrc by opcode: I-type and load = 00, store = 01, branch = 10, jal = 11, otherwise 00.
- ALU decode:
  - ALUOp 00 → add (000).
  - ALUOp 01 → sub (001).
  - ALUOp 10, `funct3=000`: sub if `{Op[5],funct7[5]}=11`, else add.
  - ALUOp 10, `funct3` 010 → slt (101), 110 → or (011), 111 → and (010).
  - ALUOp 10, any other `funct3` → add.
- Timeout (TIMEOUT_CYCLES > 0):
  - Wait states are FETCH, MEMREAD and MEMWRITE.
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments on each wait-state cycle with `mem_ready=0`.
  - The counter clears on any state change or on `mem_ready=1`.
  - On the TIMEOUT_CYCLES-th consecutive stall cycle: `mem_timeout` pulses and all write enables are forced to 0 in that cycle (MemWrite included). Next state is FETCH.
  - A timeout in FETCH re-enters FETCH with the counter cleared.
- While `rst`=0, every output is 0, including `state_o`. The state register and counter reset asynchronously to FETCH and 0.

## Timing
- Release of `rst` is synchronised by the integration. The first FETCH cycle is the first rising edge after release.
- Zero-wait-state latency in cycles, FETCH through retire:
  - R-type and I-type: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - jal: 4.
- Each cycle with `mem_ready=0` in a wait state adds one cycle.
- `mem_ready` is sampled combinationally in the same cycle. IRWrite and PCWrite rise in the same cycle `mem_ready` rises.
- `instr_done`, `illegal_instr` and `mem_timeout` last exactly one cycle each. `illegal_instr` and `instr_done` never assert together, except for an illegal branch `funct3`, where both assert.
- Reset asserted mid-instruction clears outputs immediately with no clock. No partial writes complete after reset asserts.

## Test plan
- Reset, then R-type `add` (Op=0110011, funct3=000, funct7=0), `mem_ready`=1 → `state_o` sequence 0,1,6,8,0. ALUControl=000 in EXECUTER. RegWrite=1 for exactly one cycle. `instr_done` pulses at cycle 4.
- `sub` R-type with funct7=0100000 → ALUControl=001. `addi` with funct7[5]=1 → ALUControl=000.
- lw with `mem_ready` low for 2 cycles in MEMREAD → `state_o` sequence 0,1,2,3,3,3,4. RegWrite and ResultSrc=01 only in MEMWB.
- beq with Zero=1 → PCWrite=1 in BRANCH. bne with Zero=1 → PCWrite=0. With EN_BNE=0, bne → `illegal_instr`=1.
- Opcode 1111111 → DECODE to FETCH, one `illegal_instr` pulse, no RegWrite or MemWrite.
- TIMEOUT_CYCLES=3, sw with `mem_ready` held 0 → MemWrite=1 for 2 cycles, then 0 with `mem_timeout`=1 in the 3rd cycle, then FETCH. Assert `rst` low mid-MEMWRITE → all outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Registered control FSM for the multi-cycle RV32I core: decodes the instruction once
// and sequences datapath enables, stalling on the memory ready handshake.
module multicycle_control_unit #(
  parameter bit          EN_BNE         = 1'b1,
  parameter bit          EN_JAL         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [3:0]       state_q, state_d, next_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pc_we, ir_we, mem_we, reg_we, adr_src;
  logic [1:0] res_src, src_a, src_b, alu_op, imm_src;
  logic [2:0] alu_ctrl;
  logic       done, illegal, wait_st, stall, timeout;
  logic       unused_funct7;

  assign unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    adr_src    = 1'b0;
    res_src    = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = 2'b00;
    done       = 1'b0;
    illegal    = 1'b0;
    wait_st    = 1'b0;
    next_state = S_FETCH;
    case (state_q)
      S_FETCH: begin
        wait_st    = 1'b1;
        src_b      = 2'b10;
        res_src    = 2'b10;
        ir_we      = mem_ready;
        pc_we      = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (Op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL: begin
            if (EN_JAL) next_state = S_JAL;
            else        illegal    = 1'b1;
          end
          default:           illegal    = 1'b1;
        endcase
      end
      S_MEMADR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        next_state = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        wait_st    = 1'b1;
        adr_src    = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        res_src = 2'b01;
        reg_we  = 1'b1;
        done    = 1'b1;
      end
      S_MEMWRITE: begin
        wait_st    = 1'b1;
        adr_src    = 1'b1;
        mem_we     = 1'b1;
        done       = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        src_a      = 2'b10;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we = 1'b1;
        done   = 1'b1;
      end
      S_BRANCH: begin
        src_a  = 2'b10;
        alu_op = 2'b01;
        done   = 1'b1;
        case (funct3)
          3'b000: pc_we = Zero;
          3'b001: begin
            if (EN_BNE) pc_we   = ~Zero;
            else        illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_JAL: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        pc_we      = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // The stall counter only advances while parked in a wait state; any exit
  // (including a timeout that re-enters FETCH) starts the next stall from zero.
  assign stall   = wait_st & ~mem_ready;
  assign timeout = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == CNT_LAST);
  assign state_d = timeout ? S_FETCH : next_state;

  always_comb begin
    cnt_d = '0;
    if ((TIMEOUT_CYCLES != 0) && stall && !timeout && (state_d == state_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_op)
      2'b00: alu_ctrl = 3'b000;
      2'b01: alu_ctrl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = ({Op[5], funct7[5]} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (Op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  // Outputs are gated by rst so an asserted reset silences every strobe without a clock.
  assign PCWrite       = rst & pc_we  & ~timeout;
  assign IRWrite       = rst & ir_we  & ~timeout;
  assign MemWrite      = rst & mem_we & ~timeout;
  assign RegWrite      = rst & reg_we & ~timeout;
  assign AdrSrc        = rst & adr_src;
  assign ResultSrc     = rst ? res_src  : '0;
  assign ALUSrcA       = rst ? src_a    : '0;
  assign ALUSrcB       = rst ? src_b    : '0;
  assign ImmSrc        = rst ? imm_src  : '0;
  assign ALUControl    = rst ? alu_ctrl : '0;
  assign instr_done    = rst & done & ~timeout;
  assign illegal_instr = rst & illegal;
  assign mem_timeout   = rst & timeout;
  assign state_o       = rst ? state_q : '0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit: per-cycle expected outputs are queued
// when inputs are driven and compared on the following falling edge.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, mw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       done, ill, to;
  } outs_t;

  typedef struct {
    int unsigned dut;
    string       tag;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic        mr;
    outs_t       e;
  } vec_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;
  localparam logic [6:0] F7_0      = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  logic       clk, rst, Zero, mem_ready;
  logic [6:0] Op, funct7;
  logic [2:0] funct3;

  logic       pcw0, adr0, irw0, mw0, rw0, done0, ill0, to0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic [3:0] st0;
  logic       pcw1, adr1, irw1, mw1, rw1, done1, ill1, to1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;
  logic [3:0] st1;
  outs_t      act0, act1;

  int unsigned checks = 0;
  int unsigned passed = 0;
  vec_t        tbl[$];
  vec_t        sbq[$];
  vec_t        cur;

  multicycle_control_unit #(.EN_BNE(1'b1), .EN_JAL(1'b1), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(pcw0), .AdrSrc(adr0), .IRWrite(irw0), .MemWrite(mw0),
    .RegWrite(rw0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0),
    .ALUControl(alu0), .instr_done(done0), .illegal_instr(ill0), .mem_timeout(to0),
    .state_o(st0)
  );

  multicycle_control_unit #(.EN_BNE(1'b0), .EN_JAL(1'b0), .TIMEOUT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(pcw1), .AdrSrc(adr1), .IRWrite(irw1), .MemWrite(mw1),
    .RegWrite(rw1), .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ImmSrc(imm1),
    .ALUControl(alu1), .instr_done(done1), .illegal_instr(ill1), .mem_timeout(to1),
    .state_o(st1)
  );

  assign act0 = {st0, pcw0, adr0, irw0, mw0, rw0, rs0, sa0, sb0, imm0, alu0, done0, ill0, to0};
  assign act1 = {st1, pcw1, adr1, irw1, mw1, rw1, rs1, sa1, sb1, imm1, alu1, done1, ill1, to1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic outs_t ex(int st, int pcw, int adr, int irw, int mw, int rw, int rs,
                               int sa, int sb, int imm, int alu, int done, int ill, int to);
    outs_t r;
    r.st = 4'(st);   r.pcw = 1'(pcw); r.adr = 1'(adr); r.irw = 1'(irw);
    r.mw = 1'(mw);   r.rw = 1'(rw);   r.rs = 2'(rs);   r.sa = 2'(sa);
    r.sb = 2'(sb);   r.imm = 2'(imm); r.alu = 3'(alu); r.done = 1'(done);
    r.ill = 1'(ill); r.to = 1'(to);
    return r;
  endfunction

  task automatic check(input string tag, input outs_t act, input outs_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic v(input int unsigned d, input string tag, input logic [6:0] op, input int f3,
                   input logic [6:0] f7, input int z, input int mr, input outs_t e);
    vec_t r;
    r.dut = d; r.tag = tag; r.op = op; r.f3 = 3'(f3); r.f7 = f7;
    r.z = 1'(z); r.mr = 1'(mr); r.e = e;
    tbl.push_back(r);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      Op = tbl[i].op; funct3 = tbl[i].f3; funct7 = tbl[i].f7;
      Zero = tbl[i].z; mem_ready = tbl[i].mr;
      sbq.push_back(tbl[i]);
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; Op = OP_STORE; funct3 = 3'b010; funct7 = F7_0; Zero = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    check("reset_d0", act0, '0);
    check("reset_d1", act1, '0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      check(cur.tag, (cur.dut == 0) ? act0 : act1, cur.e);
    end
  end

  initial begin
    rst = 1'b1; Op = '0; funct3 = '0; funct7 = '0; Zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset();

    // dut0: default configuration, no timeout
    v(0, "add_fetch", OP_R, 0, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "add_dec",   OP_R, 0, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "add_exr",   OP_R, 0, F7_0, 0, 1, ex(6,0,0,0,0,0,0,2,0,0,0,0,0,0));
    v(0, "add_wb",    OP_R, 0, F7_0, 0, 1, ex(8,0,0,0,0,1,0,0,0,0,0,1,0,0));
    v(0, "sub_fetch", OP_R, 0, F7_SUB, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "sub_dec",   OP_R, 0, F7_SUB, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "sub_exr",   OP_R, 0, F7_SUB, 0, 1, ex(6,0,0,0,0,0,0,2,0,0,1,0,0,0));
    v(0, "sub_wb",    OP_R, 0, F7_SUB, 0, 1, ex(8,0,0,0,0,1,0,0,0,0,0,1,0,0));
    v(0, "addi_fetch", OP_I, 0, F7_SUB, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "addi_dec",   OP_I, 0, F7_SUB, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "addi_exi",   OP_I, 0, F7_SUB, 0, 1, ex(7,0,0,0,0,0,0,2,1,0,0,0,0,0));
    v(0, "addi_wb",    OP_I, 0, F7_SUB, 0, 1, ex(8,0,0,0,0,1,0,0,0,0,0,1,0,0));
    v(0, "slti_fetch", OP_I, 2, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "slti_dec",   OP_I, 2, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "slti_exi",   OP_I, 2, F7_0, 0, 1, ex(7,0,0,0,0,0,0,2,1,0,5,0,0,0));
    v(0, "slti_wb",    OP_I, 2, F7_0, 0, 1, ex(8,0,0,0,0,1,0,0,0,0,0,1,0,0));
    v(0, "or_fetch",  OP_R, 6, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "or_dec",    OP_R, 6, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "or_exr",    OP_R, 6, F7_0, 0, 1, ex(6,0,0,0,0,0,0,2,0,0,3,0,0,0));
    v(0, "or_wb",     OP_R, 6, F7_0, 0, 1, ex(8,0,0,0,0,1,0,0,0,0,0,1,0,0));
    v(0, "and_fetch", OP_R, 7, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "and_dec",   OP_R, 7, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "and_exr",   OP_R, 7, F7_0, 0, 1, ex(6,0,0,0,0,0,0,2,0,0,2,0,0,0));
    v(0, "and_wb",    OP_R, 7, F7_0, 0, 1, ex(8,0,0,0,0,1,0,0,0,0,0,1,0,0));
    v(0, "xor_fetch", OP_R, 4, F7_SUB, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "xor_dec",   OP_R, 4, F7_SUB, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "xor_exr",   OP_R, 4, F7_SUB, 0, 1, ex(6,0,0,0,0,0,0,2,0,0,0,0,0,0));
    v(0, "xor_wb",    OP_R, 4, F7_SUB, 0, 1, ex(8,0,0,0,0,1,0,0,0,0,0,1,0,0));
    v(0, "lw_fetch",  OP_LOAD, 2, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "lw_dec",    OP_LOAD, 2, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,0,0));
    v(0, "lw_madr",   OP_LOAD, 2, F7_0, 0, 1, ex(2,0,0,0,0,0,0,2,1,0,0,0,0,0));
    v(0, "lw_mrd0",   OP_LOAD, 2, F7_0, 0, 0, ex(3,0,1,0,0,0,0,0,0,0,0,0,0,0));
    v(0, "lw_mrd1",   OP_LOAD, 2, F7_0, 0, 0, ex(3,0,1,0,0,0,0,0,0,0,0,0,0,0));
    v(0, "lw_mrd2",   OP_LOAD, 2, F7_0, 0, 1, ex(3,0,1,0,0,0,0,0,0,0,0,0,0,0));
    v(0, "lw_mwb",    OP_LOAD, 2, F7_0, 0, 1, ex(4,0,0,0,0,1,1,0,0,0,0,1,0,0));
    v(0, "sw_fetch",  OP_STORE, 2, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,1,0,0,0,0));
    v(0, "sw_dec",    OP_STORE, 2, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,1,0,0,0,0));
    v(0, "sw_madr",   OP_STORE, 2, F7_0, 0, 1, ex(2,0,0,0,0,0,0,2,1,1,0,0,0,0));
    for (int i = 0; i < 4; i++)
      v(0, $sformatf("sw_stall%0d", i), OP_STORE, 2, F7_0, 0, 0, ex(5,0,1,0,1,0,0,0,0,1,0,0,0,0));
    v(0, "sw_mwr_done", OP_STORE, 2, F7_0, 0, 1, ex(5,0,1,0,1,0,0,0,0,1,0,1,0,0));
    v(0, "beq1_fetch", OP_BR, 0, F7_0, 1, 1, ex(0,1,0,1,0,0,2,0,2,2,0,0,0,0));
    v(0, "beq1_dec",   OP_BR, 0, F7_0, 1, 1, ex(1,0,0,0,0,0,0,1,1,2,0,0,0,0));
    v(0, "beq1_br",    OP_BR, 0, F7_0, 1, 1, ex(9,1,0,0,0,0,0,2,0,2,1,1,0,0));
    v(0, "beq0_fetch", OP_BR, 0, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,2,0,0,0,0));
    v(0, "beq0_dec",   OP_BR, 0, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,2,0,0,0,0));
    v(0, "beq0_br",    OP_BR, 0, F7_0, 0, 1, ex(9,0,0,0,0,0,0,2,0,2,1,1,0,0));
    v(0, "bne1_fetch", OP_BR, 1, F7_0, 1, 1, ex(0,1,0,1,0,0,2,0,2,2,0,0,0,0));
    v(0, "bne1_dec",   OP_BR, 1, F7_0, 1, 1, ex(1,0,0,0,0,0,0,1,1,2,0,0,0,0));
    v(0, "bne1_br",    OP_BR, 1, F7_0, 1, 1, ex(9,0,0,0,0,0,0,2,0,2,1,1,0,0));
    v(0, "bne0_fetch", OP_BR, 1, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,2,0,0,0,0));
    v(0, "bne0_dec",   OP_BR, 1, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,2,0,0,0,0));
    v(0, "bne0_br",    OP_BR, 1, F7_0, 0, 1, ex(9,1,0,0,0,0,0,2,0,2,1,1,0,0));
    v(0, "blt_fetch",  OP_BR, 4, F7_0, 1, 1, ex(0,1,0,1,0,0,2,0,2,2,0,0,0,0));
    v(0, "blt_dec",    OP_BR, 4, F7_0, 1, 1, ex(1,0,0,0,0,0,0,1,1,2,0,0,0,0));
    v(0, "blt_br_ill", OP_BR, 4, F7_0, 1, 1, ex(9,0,0,0,0,0,0,2,0,2,1,1,1,0));
    v(0, "jal_fetch",  OP_JAL, 0, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,3,0,0,0,0));
    v(0, "jal_dec",    OP_JAL, 0, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,3,0,0,0,0));
    v(0, "jal_jal",    OP_JAL, 0, F7_0, 0, 1, ex(10,1,0,0,0,0,0,1,2,3,0,0,0,0));
    v(0, "jal_wb",     OP_JAL, 0, F7_0, 0, 1, ex(8,0,0,0,0,1,0,0,0,3,0,1,0,0));
    v(0, "bad_fetch",  OP_BAD, 0, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    v(0, "bad_dec",    OP_BAD, 0, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,0,0,0,1,0));
    v(0, "fstall_0",   OP_BAD, 0, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,0,0,0,0,0));
    v(0, "fstall_1",   OP_BAD, 0, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,0,0,0,0,0));
    v(0, "fstall_2",   OP_BAD, 0, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,0,0,0,0,0));
    v(0, "fstall_go",  OP_BAD, 0, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,0,0,0,0,0));
    run_table();

    do_reset();
    // dut1: bne and jal disabled, three-cycle stall timeout
    v(1, "nb_fetch",   OP_BR, 1, F7_0, 1, 1, ex(0,1,0,1,0,0,2,0,2,2,0,0,0,0));
    v(1, "nb_dec",     OP_BR, 1, F7_0, 1, 1, ex(1,0,0,0,0,0,0,1,1,2,0,0,0,0));
    v(1, "nb_br_ill",  OP_BR, 1, F7_0, 1, 1, ex(9,0,0,0,0,0,0,2,0,2,1,1,1,0));
    v(1, "nj_fetch",   OP_JAL, 0, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,3,0,0,0,0));
    v(1, "nj_dec_ill", OP_JAL, 0, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,3,0,0,1,0));
    v(1, "fto_0",      OP_STORE, 2, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,1,0,0,0,0));
    v(1, "fto_1",      OP_STORE, 2, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,1,0,0,0,0));
    v(1, "fto_hit",    OP_STORE, 2, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,1,0,0,0,1));
    v(1, "fto_clr0",   OP_STORE, 2, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,1,0,0,0,0));
    v(1, "fto_clr1",   OP_STORE, 2, F7_0, 0, 0, ex(0,0,0,0,0,0,2,0,2,1,0,0,0,0));
    v(1, "swto_fetch", OP_STORE, 2, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,1,0,0,0,0));
    v(1, "swto_dec",   OP_STORE, 2, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,1,0,0,0,0));
    v(1, "swto_madr",  OP_STORE, 2, F7_0, 0, 1, ex(2,0,0,0,0,0,0,2,1,1,0,0,0,0));
    v(1, "swto_mw0",   OP_STORE, 2, F7_0, 0, 0, ex(5,0,1,0,1,0,0,0,0,1,0,0,0,0));
    v(1, "swto_mw1",   OP_STORE, 2, F7_0, 0, 0, ex(5,0,1,0,1,0,0,0,0,1,0,0,0,0));
    v(1, "swto_hit",   OP_STORE, 2, F7_0, 0, 0, ex(5,0,1,0,0,0,0,0,0,1,0,0,0,1));
    v(1, "swto_after", OP_STORE, 2, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,1,0,0,0,0));
    v(1, "swlate_dec", OP_STORE, 2, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,1,0,0,0,0));
    v(1, "swlate_madr", OP_STORE, 2, F7_0, 0, 1, ex(2,0,0,0,0,0,0,2,1,1,0,0,0,0));
    v(1, "swlate_mw0", OP_STORE, 2, F7_0, 0, 0, ex(5,0,1,0,1,0,0,0,0,1,0,0,0,0));
    v(1, "swlate_mw1", OP_STORE, 2, F7_0, 0, 0, ex(5,0,1,0,1,0,0,0,0,1,0,0,0,0));
    v(1, "swlate_done", OP_STORE, 2, F7_0, 0, 1, ex(5,0,1,0,1,0,0,0,0,1,0,1,0,0));
    v(1, "swrst_fetch", OP_STORE, 2, F7_0, 0, 1, ex(0,1,0,1,0,0,2,0,2,1,0,0,0,0));
    v(1, "swrst_dec",  OP_STORE, 2, F7_0, 0, 1, ex(1,0,0,0,0,0,0,1,1,1,0,0,0,0));
    v(1, "swrst_madr", OP_STORE, 2, F7_0, 0, 1, ex(2,0,0,0,0,0,0,2,1,1,0,0,0,0));
    v(1, "swrst_mw0",  OP_STORE, 2, F7_0, 0, 0, ex(5,0,1,0,1,0,0,0,0,1,0,0,0,0));
    run_table();

    // Reset dropped mid-MEMWRITE: outputs must clear without waiting for a clock edge
    check("mw_pre_rst", act1, ex(5,0,1,0,1,0,0,0,0,1,0,0,0,0));
    rst = 1'b0;
    #1;
    check("rst_mid_mw_d1", act1, '0);
    check("rst_mid_mw_d0", act0, '0);
    @(posedge clk); #1;
    check("rst_hold_d1", act1, '0);
    rst = 1'b1;
    #1;
    check("rst_rel_fetch", act1, ex(0,0,0,0,0,0,2,0,2,1,0,0,0,0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
